// File: rtl/rgb_status_pkg.sv
// Shared types and default constants for the RGB status scheduler.
package rgb_status_pkg;

    // LED owner, in increasing priority order except reset which overrides all
    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    // PWM timebase width
    localparam int unsigned PWM_BITS = 8;

    // Default per-channel duty values
    localparam int unsigned DUTY_RUN  = 32;
    localparam int unsigned DUTY_HALT = 64;
    localparam int unsigned DUTY_ACT  = 16;
    localparam int unsigned DUTY_ERR  = 255;

endpackage

// File: rtl/rgb_status_scheduler_pwm_channel.sv
// One PWM output: compares the shared timebase against a duty value and registers the result.
module pwm_channel
    import rgb_status_pkg::*;
#(
    parameter int unsigned W = PWM_BITS
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] cnt_i,
    input  logic [W-1:0] duty_i,
    output logic         pwm_o
);

    logic pwm_q;
    logic pwm_d;

    // Channel is on while the timebase is below the duty threshold
    always_comb begin
        pwm_d = (cnt_i < duty_i);
    end

    // Registered pin drive
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/rgb_status_scheduler.sv
// Arbitrates the board RGB LED between reset, run, halt and error status sources.
module rgb_status_scheduler #(
    parameter int unsigned PWM_BITS  = rgb_status_pkg::PWM_BITS,
    parameter int unsigned BLINK_DIV = 3_000_000,
    parameter int unsigned ACT_HOLD  = 600_000,
    parameter logic [31:0] HALT_PC   = 32'h0000_0010,
    parameter int unsigned DUTY_RUN  = rgb_status_pkg::DUTY_RUN,
    parameter int unsigned DUTY_HALT = rgb_status_pkg::DUTY_HALT,
    parameter int unsigned DUTY_ACT  = rgb_status_pkg::DUTY_ACT,
    parameter int unsigned DUTY_ERR  = rgb_status_pkg::DUTY_ERR
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sys_reset,
    input  logic [31:0] cpu_pc,
    input  logic        cpu_reg_wr,
    input  logic        error_req,
    output logic        pwm_red,
    output logic        pwm_green,
    output logic        pwm_blue,
    output logic        halted,
    output logic [1:0]  state
);

    import rgb_status_pkg::*;

    localparam int unsigned BLINK_W = $clog2(BLINK_DIV + 1);
    localparam int unsigned ACT_W   = $clog2(ACT_HOLD + 1);

    localparam logic [PWM_BITS-1:0] DUTY_RUN_C  = PWM_BITS'(DUTY_RUN);
    localparam logic [PWM_BITS-1:0] DUTY_HALT_C = PWM_BITS'(DUTY_HALT);
    localparam logic [PWM_BITS-1:0] DUTY_ACT_C  = PWM_BITS'(DUTY_ACT);
    localparam logic [PWM_BITS-1:0] DUTY_ERR_C  = PWM_BITS'(DUTY_ERR);
    localparam logic [BLINK_W-1:0]  BLINK_LAST  = BLINK_W'(BLINK_DIV - 1);
    localparam logic [ACT_W-1:0]    ACT_LOAD    = ACT_W'(ACT_HOLD);

    state_e               state_q;
    state_e               state_d;
    logic                 halted_q;
    logic                 halted_d;
    logic [PWM_BITS-1:0]  pwm_cnt_q;
    logic [PWM_BITS-1:0]  pwm_cnt_d;
    logic [BLINK_W-1:0]   blink_cnt_q;
    logic [BLINK_W-1:0]   blink_cnt_d;
    logic                 blink_phase_q;
    logic                 blink_phase_d;
    logic [ACT_W-1:0]     act_cnt_q;
    logic [ACT_W-1:0]     act_cnt_d;

    logic                 halt_hit_c;
    logic                 stay_err_c;
    logic                 stay_run_c;
    logic [PWM_BITS-1:0]  duty_red_c;
    logic [PWM_BITS-1:0]  duty_green_c;
    logic [PWM_BITS-1:0]  duty_blue_c;

    // Full 32-bit match against the terminal self-loop address
    assign halt_hit_c = (cpu_pc == HALT_PC);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: sys_reset > error > halt > run; error is sticky until sys_reset
    always_comb begin
        state_d = state_q;
        if (sys_reset) begin
            state_d = S_RST;
        end else begin
            case (state_q)
                S_RST:  state_d = S_RUN;
                S_RUN: begin
                    if (error_req) begin
                        state_d = S_ERR;
                    end else if (halt_hit_c) begin
                        state_d = S_HALT;
                    end
                end
                S_HALT: begin
                    if (error_req) begin
                        state_d = S_ERR;
                    end
                end
                S_ERR:  state_d = S_ERR;
            endcase
        end
    end

    // Per-state duty selection feeding the PWM channels
    always_comb begin
        duty_red_c   = '0;
        duty_green_c = '0;
        duty_blue_c  = '0;
        case (state_q)
            S_RST: begin
                duty_red_c = DUTY_RUN_C;
            end
            S_RUN: begin
                duty_red_c   = DUTY_RUN_C;
                duty_green_c = (act_cnt_q != '0) ? DUTY_ACT_C : '0;
            end
            S_HALT: begin
                duty_blue_c = DUTY_HALT_C;
            end
            S_ERR: begin
                duty_red_c = blink_phase_q ? DUTY_ERR_C : '0;
            end
        endcase
    end

    // Counters only advance while the FSM remains in their owning state
    assign stay_err_c = (state_q == S_ERR) && (state_d == S_ERR);
    assign stay_run_c = (state_q == S_RUN) && (state_d == S_RUN);

    // Timebase, blink divider, activity stretcher and halt flag next values
    always_comb begin
        pwm_cnt_d     = pwm_cnt_q + PWM_BITS'(1);
        halted_d      = (state_d == S_HALT);
        blink_cnt_d   = '0;
        blink_phase_d = 1'b1;
        act_cnt_d     = '0;

        // Held at count 0 / phase on outside S_ERR so every error starts lit
        if (stay_err_c) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
                blink_phase_d = blink_phase_q;
            end
        end

        // A write (re)loads the hold time; otherwise count down to zero
        if (stay_run_c) begin
            if (cpu_reg_wr) begin
                act_cnt_d = ACT_LOAD;
            end else if (act_cnt_q != '0) begin
                act_cnt_d = act_cnt_q - ACT_W'(1);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_q     <= '0;
            halted_q      <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            act_cnt_q     <= '0;
        end else begin
            pwm_cnt_q     <= pwm_cnt_d;
            halted_q      <= halted_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            act_cnt_q     <= act_cnt_d;
        end
    end

    pwm_channel #(.W(PWM_BITS)) u_pwm_red (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .cnt_i  (pwm_cnt_q),
        .duty_i (duty_red_c),
        .pwm_o  (pwm_red)
    );

    pwm_channel #(.W(PWM_BITS)) u_pwm_green (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .cnt_i  (pwm_cnt_q),
        .duty_i (duty_green_c),
        .pwm_o  (pwm_green)
    );

    pwm_channel #(.W(PWM_BITS)) u_pwm_blue (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .cnt_i  (pwm_cnt_q),
        .duty_i (duty_blue_c),
        .pwm_o  (pwm_blue)
    );

    assign halted = halted_q;
    assign state  = state_q;

endmodule

// File: tb/tb_rgb_status_scheduler.sv
// Directed bench for rgb_status_scheduler with a cycle-level reference model and scoreboard queue.
module tb_rgb_status_scheduler;

    localparam int unsigned PB   = 4;
    localparam int unsigned BDIV = 8;
    localparam int unsigned AHLD = 5;
    localparam int unsigned D_RUN  = 4;
    localparam int unsigned D_HALT = 8;
    localparam int unsigned D_ACT  = 12;
    localparam int unsigned D_ERR  = 15;
    localparam logic [31:0] HPC  = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sys_reset;
    logic [31:0] cpu_pc;
    logic        cpu_reg_wr;
    logic        error_req;
    logic        pwm_red;
    logic        pwm_green;
    logic        pwm_blue;
    logic        halted;
    logic [1:0]  state;

    rgb_status_scheduler #(
        .PWM_BITS  (PB),
        .BLINK_DIV (BDIV),
        .ACT_HOLD  (AHLD),
        .HALT_PC   (HPC),
        .DUTY_RUN  (D_RUN),
        .DUTY_HALT (D_HALT),
        .DUTY_ACT  (D_ACT),
        .DUTY_ERR  (D_ERR)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sys_reset  (sys_reset),
        .cpu_pc     (cpu_pc),
        .cpu_reg_wr (cpu_reg_wr),
        .error_req  (error_req),
        .pwm_red    (pwm_red),
        .pwm_green  (pwm_green),
        .pwm_blue   (pwm_blue),
        .halted     (halted),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic       hl;
        logic       r;
        logic       g;
        logic       b;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests;
    int   n_fail;

    // Reference model state
    int m_st;
    int m_cnt;
    int m_bc;
    int m_act;
    bit m_ph;
    bit m_hl;
    bit m_r;
    bit m_g;
    bit m_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_bc = 0; m_act = 0;
        m_ph = 1'b0; m_hl = 1'b0; m_r = 1'b0; m_g = 1'b0; m_b = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_red"}, 32'(pwm_red), 32'd0);
        check({tag, "_green"}, 32'(pwm_green), 32'd0);
        check({tag, "_blue"}, 32'(pwm_blue), 32'd0);
        check({tag, "_pwmcnt"}, 32'(dut.pwm_cnt_q), 32'd0);
    endtask

    // One clock: advance the model at the edge, queue its prediction, compare at the falling edge
    task automatic step();
        exp_t e;
        int   dr;
        int   dg;
        int   db;
        int   nst;
        @(posedge clk);
        dr = 0; dg = 0; db = 0;
        if (m_st == 0) dr = D_RUN;
        else if (m_st == 1) begin
            dr = D_RUN;
            if (m_act > 0) dg = D_ACT;
        end
        else if (m_st == 2) db = D_HALT;
        else if (m_ph) dr = D_ERR;
        m_r = (m_cnt < dr);
        m_g = (m_cnt < dg);
        m_b = (m_cnt < db);

        if (sys_reset) nst = 0;
        else if (m_st == 0) nst = 1;
        else if ((m_st == 1 || m_st == 2) && error_req) nst = 3;
        else if (m_st == 1 && cpu_pc == HPC) nst = 2;
        else nst = m_st;

        if (m_st == 3 && nst == 3) begin
            if (m_bc == int'(BDIV) - 1) begin
                m_bc = 0;
                m_ph = !m_ph;
            end else begin
                m_bc = m_bc + 1;
            end
        end else begin
            m_bc = 0;
            m_ph = 1'b1;
        end

        if (m_st == 1 && nst == 1) begin
            if (cpu_reg_wr) m_act = AHLD;
            else if (m_act > 0) m_act = m_act - 1;
        end else begin
            m_act = 0;
        end

        m_cnt = (m_cnt + 1) % 16;
        m_st  = nst;
        m_hl  = (nst == 2);

        e.st = 2'(m_st); e.hl = m_hl; e.r = m_r; e.g = m_g; e.b = m_b; e.cnt = 4'(m_cnt);
        sb_q.push_back(e);

        @(negedge clk);
        e = sb_q.pop_front();
        check("sb_state", 32'(state), 32'(e.st));
        check("sb_halted", 32'(halted), 32'(e.hl));
        check("sb_red", 32'(pwm_red), 32'(e.r));
        check("sb_green", 32'(pwm_green), 32'(e.g));
        check("sb_blue", 32'(pwm_blue), 32'(e.b));
        check("sb_pwmcnt", 32'(dut.pwm_cnt_q), 32'(e.cnt));
    endtask

    initial begin
        int cnt_r;
        int cnt_b;
        int act_n;

        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b1;
        sys_reset = 1'b1;
        cpu_pc = 32'd0;
        cpu_reg_wr = 1'b0;
        error_req = 1'b0;
        model_reset();

        // Power-on reset
        #1 reset_n = 1'b0;
        #1;
        check_all_zero("por");
        @(negedge clk);
        reset_n = 1'b1;

        // Held in S_RST by sys_reset: red at DUTY_RUN
        cnt_r = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (pwm_red) cnt_r++;
        end
        check("rst_red_count", 32'(cnt_r), 32'd4);
        check("rst_state", 32'(state), 32'd0);

        // Run, then halt
        sys_reset = 1'b0;
        step();
        check("run_state", 32'(state), 32'd1);
        step();
        cpu_pc = HPC;
        step();
        check("halt_state", 32'(state), 32'd2);
        check("halt_flag", 32'(halted), 32'd1);
        step();
        cnt_r = 0;
        cnt_b = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (pwm_red) cnt_r++;
            if (pwm_blue) cnt_b++;
        end
        check("halt_blue_count", 32'(cnt_b), 32'd8);
        check("halt_red_count", 32'(cnt_r), 32'd0);
        cpu_pc = 32'h14;
        repeat (4) step();
        check("halt_sticky_flag", 32'(halted), 32'd1);
        check("halt_sticky_state", 32'(state), 32'd2);

        // Back to run
        sys_reset = 1'b1;
        cpu_pc = 32'd0;
        step();
        sys_reset = 1'b0;
        step();
        check("rerun_state", 32'(state), 32'd1);
        check("rerun_halted", 32'(halted), 32'd0);

        // Activity: single write holds for ACT_HOLD cycles
        act_n = 0;
        for (int i = 0; i < 10; i++) begin
            cpu_reg_wr = (i == 0);
            step();
            if (dut.act_cnt_q != '0) act_n++;
        end
        cpu_reg_wr = 1'b0;
        check("act_single_len", 32'(act_n), 32'd5);
        repeat (2) step();

        // Activity: retrigger at cycle 3
        act_n = 0;
        for (int i = 0; i < 12; i++) begin
            cpu_reg_wr = (i == 0 || i == 3);
            step();
            if (dut.act_cnt_q != '0) act_n++;
        end
        cpu_reg_wr = 1'b0;
        check("act_retrig_len", 32'(act_n), 32'd8);
        repeat (3) step();

        // Error wins over simultaneous halt match
        cpu_pc = HPC;
        error_req = 1'b1;
        step();
        check("err_state", 32'(state), 32'd3);
        check("err_halted", 32'(halted), 32'd0);
        error_req = 1'b0;
        cpu_pc = 32'd0;
        check("blink_phase_start", 32'(dut.blink_phase_q), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            step();
            check("blink_phase", 32'(dut.blink_phase_q), 32'((i % 16) < 8));
        end
        check("err_sticky", 32'(state), 32'd3);

        // Recovery through a one-cycle sys_reset
        sys_reset = 1'b1;
        step();
        sys_reset = 1'b0;
        check("rec_state_rst", 32'(state), 32'd0);
        check("rec_blink_cnt", 32'(dut.blink_cnt_q), 32'd0);
        check("rec_act_cnt", 32'(dut.act_cnt_q), 32'd0);
        check("rec_blink_phase", 32'(dut.blink_phase_q), 32'd1);
        step();
        check("rec_state_run", 32'(state), 32'd1);

        // Forty PWM periods in S_RUN
        for (int p = 0; p < 40; p++) begin
            cnt_r = 0;
            for (int k = 0; k < 16; k++) begin
                step();
                if (pwm_red) cnt_r++;
            end
            check("wrap_red_count", 32'(cnt_r), 32'd4);
        end

        // Asynchronous reset asserted mid-cycle
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        sb_q.delete();
        check_all_zero("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        step();
        step();
        check("post_rst_run", 32'(state), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
